// File: rtl/pipelined_rca_adder_if.sv
// Valid/ready operand and result stream for the pipelined ripple-carry adder.
interface pipelined_rca_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_rca_adder.sv
// WIDTH-bit add/subtract split into STAGES ripple slices, one slice per pipeline stage,
// with operand skew and result deskew registers and a global-stall valid/ready wrapper.
module pipelined_rca_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_rca_adder_if.slave stream_io
);
  localparam int SW = WIDTH / STAGES;

  logic             stall;
  logic             accept;
  logic [WIDTH-1:0] bb0;
  logic             c0;

  // Whole pipeline freezes (bubbles included) while the head result is refused.
  assign stall              = stream_io.out_valid & ~stream_io.out_ready;
  assign stream_io.in_ready = ~stall;
  assign accept             = stream_io.in_valid & ~stall;
  assign bb0                = stream_io.sub ? ~stream_io.b : stream_io.b;
  assign c0                 = stream_io.sub | stream_io.cin;

  // Returns {carry out of each bit, sum bits} for one SW-bit ripple slice.
  function automatic logic [2*SW-1:0] rca_slice(input logic [SW-1:0] x,
                                                input logic [SW-1:0] y,
                                                input logic          ci);
    logic          c;
    logic [SW-1:0] s;
    logic [SW-1:0] co;
    c  = ci;
    s  = '0;
    co = '0;
    for (int i = 0; i < SW; i++) begin
      s[i]  = x[i] ^ y[i] ^ c;
      c     = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      co[i] = c;
    end
    return {co, s};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SW;
    localparam int HI = LO + SW;

    logic            vld_d;
    logic            vld_q;
    logic [SW-1:0]   x_op;
    logic [SW-1:0]   y_op;
    logic            c_in;
    logic [2*SW-1:0] slice;
    logic [HI-1:0]   sum_d;
    logic [HI-1:0]   sum_q;
    logic [HI-1:0]   cout_d;
    logic [HI-1:0]   cout_q;

    if (k == 0) begin : g_head
      assign vld_d  = accept;
      assign x_op   = stream_io.a[SW-1:0];
      assign y_op   = bb0[SW-1:0];
      assign c_in   = c0;
      assign sum_d  = slice[SW-1:0];
      assign cout_d = slice[2*SW-1:SW];
    end else begin : g_body
      assign vld_d  = g_stage[k-1].vld_q;
      assign x_op   = g_stage[k-1].g_skew.a_q[HI-1:LO];
      assign y_op   = g_stage[k-1].g_skew.bb_q[HI-1:LO];
      assign c_in   = g_stage[k-1].cout_q[LO-1];
      assign sum_d  = {slice[SW-1:0], g_stage[k-1].sum_q};
      assign cout_d = {slice[2*SW-1:SW], g_stage[k-1].cout_q};
    end

    assign slice = rca_slice(x_op, y_op, c_in);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q  <= 1'b0;
        sum_q  <= '0;
        cout_q <= '0;
      end else if (!stall) begin
        vld_q  <= vld_d;
        sum_q  <= sum_d;
        cout_q <= cout_d;
      end
    end

    // Operand bits not yet consumed ride along until their slice executes.
    if (HI < WIDTH) begin : g_skew
      logic [WIDTH-1:HI] a_d;
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] bb_d;
      logic [WIDTH-1:HI] bb_q;

      if (k == 0) begin : g_src_in
        assign a_d  = stream_io.a[WIDTH-1:HI];
        assign bb_d = bb0[WIDTH-1:HI];
      end else begin : g_src_prev
        assign a_d  = g_stage[k-1].g_skew.a_q[WIDTH-1:HI];
        assign bb_d = g_stage[k-1].g_skew.bb_q[WIDTH-1:HI];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q  <= '0;
          bb_q <= '0;
        end else if (!stall) begin
          a_q  <= a_d;
          bb_q <= bb_d;
        end
      end
    end
  end

  assign stream_io.out_valid = g_stage[STAGES-1].vld_q;
  assign stream_io.sum       = g_stage[STAGES-1].sum_q;
  assign stream_io.cout      = g_stage[STAGES-1].cout_q;

  if (WIDTH == 1) begin : g_ovf_1
    assign stream_io.ovf = g_stage[STAGES-1].cout_q[0];
  end else begin : g_ovf_n
    assign stream_io.ovf = g_stage[STAGES-1].cout_q[WIDTH-1] ^ g_stage[STAGES-1].cout_q[WIDTH-2];
  end
endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Drives four adder instances (STAGES 4, 1, 2, 16) with one stream and checks each
// against an arithmetic reference model, including stall, latency and reset behaviour.
module tb_pipelined_rca_adder;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic [W-1:0] cout;
    logic         ovf;
    logic [31:0]  acc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_rca_adder_if #(.WIDTH(W)) bus4 ();
  pipelined_rca_adder_if #(.WIDTH(W)) bus1 ();
  pipelined_rca_adder_if #(.WIDTH(W)) bus2 ();
  pipelined_rca_adder_if #(.WIDTH(W)) bus16 ();

  pipelined_rca_adder #(.WIDTH(W), .STAGES(4))  dut4  (.clk(clk), .rst_n(rst_n), .stream_io(bus4));
  pipelined_rca_adder #(.WIDTH(W), .STAGES(1))  dut1  (.clk(clk), .rst_n(rst_n), .stream_io(bus1));
  pipelined_rca_adder #(.WIDTH(W), .STAGES(2))  dut2  (.clk(clk), .rst_n(rst_n), .stream_io(bus2));
  pipelined_rca_adder #(.WIDTH(W), .STAGES(16)) dut16 (.clk(clk), .rst_n(rst_n), .stream_io(bus16));

  // Secondary instances see exactly the beats the main instance accepts and never stall.
  assign bus1.in_valid   = bus4.in_valid & bus4.in_ready;
  assign bus1.a          = bus4.a;
  assign bus1.b          = bus4.b;
  assign bus1.cin        = bus4.cin;
  assign bus1.sub        = bus4.sub;
  assign bus1.out_ready  = 1'b1;
  assign bus2.in_valid   = bus4.in_valid & bus4.in_ready;
  assign bus2.a          = bus4.a;
  assign bus2.b          = bus4.b;
  assign bus2.cin        = bus4.cin;
  assign bus2.sub        = bus4.sub;
  assign bus2.out_ready  = 1'b1;
  assign bus16.in_valid  = bus4.in_valid & bus4.in_ready;
  assign bus16.a         = bus4.a;
  assign bus16.b         = bus4.b;
  assign bus16.cin       = bus4.cin;
  assign bus16.sub       = bus4.sub;
  assign bus16.out_ready = 1'b1;

  logic         ov  [4];
  logic         rdy [4];
  logic         of  [4];
  logic [W-1:0] sm  [4];
  logic [W-1:0] co  [4];
  assign ov[0] = bus4.out_valid;  assign rdy[0] = bus4.out_ready;  assign sm[0] = bus4.sum;  assign co[0] = bus4.cout;  assign of[0] = bus4.ovf;
  assign ov[1] = bus1.out_valid;  assign rdy[1] = bus1.out_ready;  assign sm[1] = bus1.sum;  assign co[1] = bus1.cout;  assign of[1] = bus1.ovf;
  assign ov[2] = bus2.out_valid;  assign rdy[2] = bus2.out_ready;  assign sm[2] = bus2.sum;  assign co[2] = bus2.cout;  assign of[2] = bus2.ovf;
  assign ov[3] = bus16.out_valid; assign rdy[3] = bus16.out_ready; assign sm[3] = bus16.sum; assign co[3] = bus16.cout; assign of[3] = bus16.ovf;

  int   stg [4] = '{4, 1, 2, 16};
  exp_t q [4][$];
  int   n_checks   = 0;
  int   n_errors   = 0;
  int   step_no    = 0;
  int   last_stall = -1;
  int   stall_cnt  = 0;
  int   stall_left = 0;
  logic arm_stall  = 1'b0;
  logic held_v     = 1'b0;
  exp_t held;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Carry out of bit i is bit i+1 of the plain sum of the low i+1 operand bits.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input int acc);
    exp_t         e;
    logic [W-1:0] bb;
    int unsigned  c0, t, m;
    bb = sub ? ~b : b;
    c0 = sub ? 1 : (cin ? 1 : 0);
    e  = '0;
    for (int i = 0; i < W; i++) begin
      m = (32'd1 << (i + 1)) - 32'd1;
      t = (32'(a) & m) + (32'(bb) & m) + c0;
      e.cout[i] = t[i+1];
    end
    e.sum = 16'(32'(a) + 32'(bb) + c0);
    e.ovf = e.cout[W-1] ^ e.cout[W-2];
    e.acc = 32'(acc);
    return e;
  endfunction

  task automatic monitor();
    exp_t e;
    if (held_v) begin
      check_eq("stall_valid_held", 32'(ov[0]), 32'd1);
      check_eq("stall_sum_stable", 32'(sm[0]), 32'(held.sum));
      check_eq("stall_cout_stable", 32'(co[0]), 32'(held.cout));
      check_eq("stall_ovf_stable", 32'(of[0]), 32'(held.ovf));
    end
    check_eq("in_ready", 32'(bus4.in_ready), 32'(!(ov[0] && !rdy[0])));
    for (int n = 0; n < 4; n++) begin
      if (ov[n]) begin
        if (q[n].size() == 0) begin
          check_eq($sformatf("spurious_out_s%0d", stg[n]), 32'(ov[n]), 32'd0);
        end else if (rdy[n]) begin
          e = q[n].pop_front();
          check_eq($sformatf("sum_s%0d", stg[n]), 32'(sm[n]), 32'(e.sum));
          check_eq($sformatf("cout_s%0d", stg[n]), 32'(co[n]), 32'(e.cout));
          check_eq($sformatf("ovf_s%0d", stg[n]), 32'(of[n]), 32'(e.ovf));
          if (n > 0 || int'(e.acc) > last_stall)
            check_eq($sformatf("latency_s%0d", stg[n]), 32'(step_no - int'(e.acc)), 32'(stg[n]));
        end
      end
    end
    if (ov[0] && !rdy[0]) begin
      held_v     = 1'b1;
      held       = '0;
      held.sum   = sm[0];
      held.cout  = co[0];
      held.ovf   = of[0];
      last_stall = step_no;
      stall_cnt++;
    end else begin
      held_v = 1'b0;
    end
    if (bus4.in_valid && bus4.in_ready) begin
      e = model(bus4.a, bus4.b, bus4.cin, bus4.sub, step_no);
      for (int n = 0; n < 4; n++) q[n].push_back(e);
    end
    step_no++;
  endtask

  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic c, input logic s, input logic r, output logic acc);
    @(negedge clk);
    if (arm_stall && ov[0]) begin
      arm_stall  = 1'b0;
      stall_left = 3;
    end
    bus4.in_valid  = v;
    bus4.a         = a;
    bus4.b         = b;
    bus4.cin       = c;
    bus4.sub       = s;
    bus4.out_ready = (stall_left > 0) ? 1'b0 : r;
    if (stall_left > 0) stall_left--;
    #1;
    acc = v && bus4.in_ready;
    monitor();
  endtask

  task automatic drain(input int cycles);
    logic acc;
    for (int i = 0; i < cycles; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    logic acc;
    int   idx;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.cin       = 1'b0;
    bus4.sub       = 1'b0;
    bus4.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_eq("reset_out_valid", 32'(ov[0]), 32'd0);
    check_eq("reset_sum", 32'(sm[0]), 32'd0);
    check_eq("reset_cout", 32'(co[0]), 32'd0);
    check_eq("reset_ovf", 32'(of[0]), 32'd0);
    #2 rst_n = 1'b1;
    #1 check_eq("ready_after_reset", 32'(bus4.in_ready), 32'd1);

    step(1'b1, 16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, acc); drain(18);
    step(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, acc); drain(18);
    step(1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, acc); drain(18);
    step(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, acc); drain(18);
    step(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b1, acc); drain(18);

    // Eight back-to-back beats, three refused cycles right after the first result.
    idx       = 0;
    stall_cnt = 0;
    arm_stall = 1'b1;
    for (int cyc = 0; cyc < 80 && (idx < 8 || q[0].size() > 0); cyc++) begin
      step(idx < 8, 16'(idx), 16'hFFFF, 1'b1, 1'b0, 1'b1, acc);
      if (acc) idx++;
    end
    check_eq("stream_beats_sent", 32'(idx), 32'd8);
    check_eq("stream_stall_cycles", 32'(stall_cnt), 32'd3);
    drain(18);

    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3) != 0, acc);
    drain(24);

    // Asynchronous reset mid-flight discards everything in the pipe.
    for (int i = 0; i < 5; i++) step(1'b1, 16'(i * 1234 + 1), 16'h0F0F, 1'b0, 1'b0, 1'b1, acc);
    @(negedge clk);
    bus4.in_valid = 1'b0;
    check_eq("pre_reset_valid", 32'(ov[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midreset_out_valid", 32'(ov[0]), 32'd0);
    check_eq("midreset_sum", 32'(sm[0]), 32'd0);
    check_eq("midreset_cout", 32'(co[0]), 32'd0);
    check_eq("midreset_ovf", 32'(of[0]), 32'd0);
    for (int n = 0; n < 4; n++) q[n].delete();
    held_v = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    drain(20);
    step(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, acc);
    drain(20);

    for (int n = 0; n < 4; n++)
      check_eq($sformatf("pending_s%0d", stg[n]), 32'(q[n].size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/pipelined_rca_adder.md
Name: pipelined_rca_adder

Overview:
- Parametrised, pipelined successor to the 4-bit combinational ripple-carry adder.
- Splits a WIDTH-bit add/subtract into STAGES equal ripple slices, with registered carry between slices and operand skew/deskew registers.
- Wraps the datapath in a valid/ready stream interface.
- Sits between operand sources (ALU front end, accumulator loops) and consumers that need a registered sum, per-bit carry chain and overflow flag.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of STAGES.
- STAGES, 4, pipeline slices; slice width SW = WIDTH/STAGES; legal range 1..WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in; ignored when sub=1.
- sub  in  1  0 = A+B+cin; 1 = A+~B+1, i.e. A−B.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  result bits.
- cout  out  WIDTH  per-bit carry chain; cout[i] = carry out of bit i; cout[WIDTH-1] is the final carry (no-borrow flag when sub=1).
- ovf  out  1  signed overflow: cout[WIDTH-1] ^ cout[WIDTH-2]; equals cout[0] when WIDTH=1.

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage valid bits and out_valid = 0.
  - All data/carry registers, sum, cout and ovf = 0.
  - in_ready = 1 once reset is released.
  - Reset mid-operation discards every in-flight beat; nothing is replayed.
- Accept: a beat transfers when in_valid && in_ready.
  - Internal effective operands: bb = sub ? ~b : b; c0 = sub ? 1 : cin.
- Slice k (k = 0..STAGES-1) computes bits [k*SW +: SW] in pipeline stage k.
  - Each bit i: s_i = a_i ^ bb_i ^ c_(i-1); c_i = (a_i & bb_i) | (c_(i-1) & (a_i ^ bb_i)); c_(-1) = c0.
  - The slice carry-in comes from the stage k−1 carry register.
  - Upper operand bits travel through skew registers until their slice executes.
  - Lower sum/carry bits travel through deskew registers so all bits of one beat present together.
- Latency: exactly STAGES cycles from the accepting edge to out_valid high, with no stall.
  - Throughput: 1 beat/cycle.
  - STAGES=1 gives a single registered full-width ripple add.
- Backpressure uses a global stall: stall = out_valid && !out_ready.
  - in_ready = !stall (combinational from out_valid/out_ready only; no dependence on in_valid).
  - While stalled, every pipeline register holds, including bubbles.
  - sum/cout/ovf stay stable while out_valid=1 and out_ready=0.
- Ordering: results leave strictly in acceptance order; no beat is dropped or duplicated.
- Bubbles: cycles with no accept insert invalid stages. Bubbles are not collapsed; under global stall they hold in place.
- Simultaneous accept and output transfer in one cycle are legal; the pipeline advances by one.
- Outputs are registered; no combinational path from a/b/cin/sub to sum/cout/ovf.
- Arithmetic is modulo 2^WIDTH; the final carry is reported only on cout[WIDTH-1].
- Data registers may update on bubbles, but sum/cout/ovf must not change while out_valid=1 and not transferred.

Test Plan:
- WIDTH=16, STAGES=4, no stall. Accept a=0x00FF, b=0x0001, cin=0, sub=0 → after 4 cycles: out_valid=1, sum=0x0100, cout=0x00FF, ovf=0.
- Signed overflow. a=0x7FFF, b=0x0001, sub=0 → sum=0x8000, cout[15]=0, cout[14]=1, ovf=1.
- Subtract. a=0x0005, b=0x0007, sub=1, cin=1 (ignored) → sum=0xFFFE, cout[15]=0, ovf=0.
  - Then a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1, cout[15]=1.
- Back-to-back streaming plus stall.
  - Feed 8 consecutive beats a=i, b=0xFFFF, cin=1 (i=0..7).
  - Hold out_ready=0 for 3 cycles after the first result.
  - Required: in_ready=0 during the stall, result held stable, sums 0x0000..0x0007 in order with cout[15]=1 each, none lost.
- Carry across every slice boundary. a=0xFFFF, b=0x0000, cin=1 → sum=0x0000, cout=0xFFFF, ovf=0.
  - Repeat with STAGES=1, 2, 16: same result, with latency 1, 2 and 16 cycles respectively.
- Reset mid-flight. Accept 3 beats, assert rst_n=0 for 1 cycle asynchronously mid-cycle.
  - Required: out_valid and sum drop to 0 immediately.
  - No stale result appears afterwards.
  - The first beat accepted after release emerges after exactly STAGES cycles.
